uart_byte_rx: RTL and testbench
===============================

UART_BYTE_RX -- requirements
Module: uart_byte_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per serial bit (legal range 4..1023).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port ready  input  1  consumer accepts the held byte when ready and valid are both high.
REQ-006 SHALL have port clr_err  input  1  clears the sticky error flags.
REQ-007 SHALL have port data  output  8  received byte, feeding the downstream 8-bit register d input.
REQ-008 SHALL have port valid  output  1  data holds an unconsumed byte.
REQ-009 SHALL have port frame_err  output  1  sticky; set when a stop bit is sampled low.
REQ-010 SHALL have port overrun  output  1  sticky; set when a byte completes while valid is high and ready is low.

Function
REQ-011 SHALL pass rx through a two-flop synchronizer; all decisions use the synchronized value rs (2-cycle input latency).
REQ-012 SHALL implement states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-013 IDLE: on rs=0, SHALL go to START and clear the bit-timer.
REQ-014 START: at timer = CLKS_PER_BIT/2 - 1 (integer division), SHALL go to DATA if rs=0; otherwise (false start) return to IDLE with no flag change.
REQ-015 DATA: SHALL sample rs every CLKS_PER_BIT cycles after the mid-start point, for 8 bits, LSB first into a shift register; after bit 7 SHALL go to STOP.
REQ-016 STOP: SHALL sample rs one bit period after bit 7. If rs=1, the byte completes and the FSM returns to IDLE. If rs=0, SHALL set frame_err, discard the byte, and go to WAIT_IDLE.
REQ-017 WAIT_IDLE: SHALL stay until rs=1, then go to IDLE (prevents re-triggering on a break condition).
REQ-018 On completion with valid=0, or with valid=1 and ready=1 in the same cycle, SHALL load data and hold valid=1 from the next cycle.
REQ-019 On completion with valid=1 and ready=0, SHALL keep the old data and valid, drop the new byte, and set overrun.
REQ-020 With valid=1 and ready=1 and no completion, SHALL clear valid next cycle; data SHALL remain unchanged.
REQ-021 data SHALL change only on a load; valid SHALL never drop without ready.
REQ-022 clr_err=1 SHALL clear frame_err and overrun next cycle. If a set event coincides with clr_err, the set SHALL win.
REQ-023 The bit-timer SHALL be sized $clog2(CLKS_PER_BIT) bits and SHALL wrap to 0 at CLKS_PER_BIT-1.

Reset
REQ-024 reset_n=0 SHALL immediately force: state=IDLE, timer=0, bit count=0, shift register=0, data=8'h00, valid=0, frame_err=0, overrun=0, and both synchronizer flops=1.
REQ-025 Reset asserted mid-frame SHALL abandon the frame. After release, the FSM SHALL wait for a fresh falling edge; any remaining bits of the abandoned frame SHALL be ignored until the line is idle-high and falls again.

Structure
REQ-026 A shared package SHALL hold the state enum typedef, DATA_W=8, and the default CLKS_PER_BIT constant.
REQ-027 The two-flop synchronizer SHALL be a separate sub-module, sync2, with a parameterized reset value (here 1).
REQ-028 The block SHALL contain no latches, one clock domain, and no combinational path from rx to any output.

Verification (bench CLKS_PER_BIT=4)
REQ-029 Send 0xA5 (start, 1,0,1,0,0,1,0,1, stop), ready=0 -> data=8'hA5 and valid=1 held; frame_err=0; assert ready for 1 cycle -> valid=0, data still 8'hA5.
REQ-030 Glitch rx low for 1 clk only -> no state beyond START, valid stays 0, flags stay 0.
REQ-031 Send 0x3C with stop bit low, then hold rx low for 20 cycles, then high, then send 0x81 -> frame_err=1, valid=0 until the 0x81 stop bit, then data=8'h81.
REQ-032 Send 0x11, hold ready=0, send 0x22 -> overrun=1 and data=8'h11; pulse clr_err -> overrun=0.
REQ-033 Send 0x11, then assert ready exactly in the 0x22 completion cycle -> data=8'h22, valid=1, overrun=0.
REQ-034 Assert reset_n=0 during bit 3 of 0xF0, release it, then send 0x5A -> outputs zero during reset; first received byte is 8'h5A with no frame_err.

Source files
------------

// File: rtl/uart_byte_rx_pkg.sv
// Shared definitions for the uart_byte_rx receiver.
//   DATA_W           : width of one received character
//   CLKS_PER_BIT_DEF : default clk cycles per serial bit
//   state_e          : receiver FSM state encoding (also exported for debug)
package uart_byte_rx_pkg;
  localparam int DATA_W           = 8;
  localparam int CLKS_PER_BIT_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_e;
endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
//   clk     : destination clock
//   reset_n : asynchronous active-low reset, both flops load RST_VAL
//   d_i     : asynchronous input
//   q_o     : synchronized output (two cycles of latency)
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/uart_byte_rx.sv
// UART byte receiver: 8 data bits, LSB first, one stop bit, no parity.
//   clk       : single clock
//   reset_n   : asynchronous active-low reset
//   rx        : asynchronous serial line, idle high
//   ready     : consumer accepts the held byte
//   clr_err   : clears frame_err and overrun (a coinciding set wins)
//   data      : received byte, changes only when a new byte is loaded
//   valid     : data holds an unconsumed byte
//   frame_err : sticky, stop bit sampled low
//   overrun   : sticky, byte completed while valid=1 and ready=0
//   state_o   : FSM state, debug visibility only
//
// Handshake: a byte is transferred on every rising edge where valid and
// ready are both high. valid never drops without such a transfer. A new
// byte is loaded only when the holding register is empty or being emptied
// in that same cycle; otherwise the new byte is dropped and overrun set.
module uart_byte_rx
  import uart_byte_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx,
  input  logic              ready,
  input  logic              clr_err,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              frame_err,
  output logic              overrun,
  output state_e            state_o
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_MID  = TW'(CLKS_PER_BIT / 2 - 1);

  logic rs;

  state_e            state_q,     state_d;
  logic [TW-1:0]     timer_q,     timer_d;
  logic [2:0]        bit_cnt_q,   bit_cnt_d;
  logic [DATA_W-1:0] shift_q,     shift_d;
  logic [DATA_W-1:0] data_q,      data_d;
  logic              valid_q,     valid_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q,   overrun_d;

  logic byte_ok;
  logic stop_bad;
  logic timer_wrap;

  // Synchronizer resets to idle-high so a reset never fabricates a start edge.
  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (rx),
    .q_o     (rs)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    byte_ok     = 1'b0;
    stop_bad    = 1'b0;
    timer_wrap  = (timer_q == T_LAST);

    unique case (state_q)
      ST_IDLE: begin
        if (!rs) begin
          state_d = ST_START;
          timer_d = '0;
        end
      end
      ST_START: begin
        // Re-check the line at the middle of the start bit to reject glitches.
        if (timer_q == T_MID) begin
          timer_d = '0;
          if (!rs) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_DATA: begin
        if (timer_wrap) begin
          timer_d   = '0;
          shift_d   = {rs, shift_q[DATA_W-1:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_STOP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_STOP: begin
        if (timer_wrap) begin
          timer_d = '0;
          if (rs) begin
            byte_ok = 1'b1;
            state_d = ST_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = ST_WAIT_IDLE;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_WAIT_IDLE: begin
        // A held-low line (break) must return high before a new start counts.
        if (rs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (byte_ok && (!valid_q || ready)) begin
      data_d  = shift_q;
      valid_d = 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end

    // Clear first, then set, so a coinciding set event wins.
    frame_err_d = (frame_err_q & ~clr_err) | stop_bad;
    overrun_d   = (overrun_q & ~clr_err) | (byte_ok & valid_q & ~ready);
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign state_o   = state_q;
endmodule

// File: tb/tb_uart_byte_rx.sv
module tb_uart_byte_rx;
  import uart_byte_rx_pkg::*;

  localparam int CPB = 4;
  // Edges from driving the start bit to the edge that samples the stop bit:
  // 2 synchronizer + 1 idle detect + half bit + 9 full bits.
  localparam int unsigned LAT = 3 + CPB / 2 + 9 * CPB;
  localparam int EW = 41;  // {completion cycle[31:0], stop_ok, data[7:0]}

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx;
  logic       ready;
  logic       clr_err;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  state_e     state_o;

  uart_byte_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (rx),
    .ready     (ready),
    .clr_err   (clr_err),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .state_o   (state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;

  logic [EW-1:0] exp_q[$];
  logic [7:0]    m_data  = '0;
  logic          m_valid = 1'b0;
  logic          m_fe    = 1'b0;
  logic          m_ov    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Model: frames complete LAT edges after their start bit was driven;
  // the holding register and flags follow the handshake rules.
  initial begin
    logic [EW-1:0] e;
    logic          done_ok, done_bad;
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset_n) begin
        m_data = '0; m_valid = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
        exp_q.delete();
      end else begin
        done_ok  = 1'b0;
        done_bad = 1'b0;
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          if (e[40:9] == cyc) begin
            void'(exp_q.pop_front());
            if (e[8]) done_ok = 1'b1;
            else      done_bad = 1'b1;
          end
        end
        m_fe = (m_fe && !clr_err) || done_bad;
        m_ov = (m_ov && !clr_err) || (done_ok && m_valid && !ready);
        if (done_ok && (!m_valid || ready)) begin
          m_data  = e[7:0];
          m_valid = 1'b1;
        end else if (m_valid && ready) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        chk("rst_data", 32'(data), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        chk("rst_state", 32'(state_o), 32'(ST_IDLE));
      end else begin
        chk("cyc_data", 32'(data), 32'(m_data));
        chk("cyc_valid", 32'(valid), 32'(m_valid));
        chk("cyc_frame_err", 32'(frame_err), 32'(m_fe));
        chk("cyc_overrun", 32'(overrun), 32'(m_ov));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame; returns #1 after the edge preceding the stop-bit sample.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    step();
    exp_q.push_back({32'(cyc + LAT), stop_bit, b});
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = stop_bit;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_ready();
    step();
    ready = 1'b1;
    step();
    ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    step();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    rx      = 1'b1;
    ready   = 1'b0;
    clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (4) step();

    // 0xA5 held with ready low, then consumed.
    send_frame(8'hA5, 1'b1);
    wait_done();
    chk("a5_data", 32'(data), 32'hA5);
    chk("a5_valid", 32'(valid), 32'h1);
    chk("a5_fe", 32'(frame_err), 32'h0);
    repeat (6) @(negedge clk);
    chk("a5_held", 32'(valid), 32'h1);
    pulse_ready();
    chk("a5_consumed_valid", 32'(valid), 32'h0);
    chk("a5_consumed_data", 32'(data), 32'hA5);

    // One-cycle glitch: never gets past START.
    step();
    rx = 1'b0;
    step();
    rx = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("glitch_state", 32'(state_o == ST_IDLE || state_o == ST_START), 32'h1);
    end
    chk("glitch_valid", 32'(valid), 32'h0);
    chk("glitch_fe", 32'(frame_err), 32'h0);

    // 0x3C with low stop bit, break, then 0x81.
    send_frame(8'h3C, 1'b0);
    wait_done();
    chk("3c_fe", 32'(frame_err), 32'h1);
    chk("3c_valid", 32'(valid), 32'h0);
    repeat (20) step();
    rx = 1'b1;
    repeat (8) step();
    chk("brk_valid", 32'(valid), 32'h0);
    send_frame(8'h81, 1'b1);
    chk("81_pre_valid", 32'(valid), 32'h0);
    wait_done();
    chk("81_data", 32'(data), 32'h81);
    chk("81_valid", 32'(valid), 32'h1);
    chk("81_fe_sticky", 32'(frame_err), 32'h1);
    step();
    ready   = 1'b1;
    clr_err = 1'b1;
    step();
    ready   = 1'b0;
    clr_err = 1'b0;
    @(negedge clk);
    chk("81_clr_fe", 32'(frame_err), 32'h0);

    // Overrun: 0x22 arrives while 0x11 is still held.
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    wait_done();
    chk("ovr_flag", 32'(overrun), 32'h1);
    chk("ovr_data", 32'(data), 32'h11);
    chk("ovr_valid", 32'(valid), 32'h1);
    pulse_clr();
    chk("ovr_cleared", 32'(overrun), 32'h0);
    pulse_ready();
    chk("ovr_consumed", 32'(valid), 32'h0);

    // Ready exactly in the completion cycle of 0x22: load, no overrun.
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    ready = 1'b1;
    step();
    ready = 1'b0;
    @(negedge clk);
    chk("swap_data", 32'(data), 32'h22);
    chk("swap_valid", 32'(valid), 32'h1);
    chk("swap_overrun", 32'(overrun), 32'h0);
    pulse_ready();
    chk("swap_consumed", 32'(valid), 32'h0);

    // Reset during bit 3 of 0xF0, release during bit 4, then 0x5A.
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (18) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_data", 32'(data), 32'h0);
        chk("mid_rst_valid", 32'(valid), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
      end
    join
    repeat (4) step();
    chk("post_rst_valid", 32'(valid), 32'h0);
    send_frame(8'h5A, 1'b1);
    wait_done();
    chk("5a_data", 32'(data), 32'h5A);
    chk("5a_valid", 32'(valid), 32'h1);
    chk("5a_fe", 32'(frame_err), 32'h0);
    chk("model_drained", 32'(exp_q.size()), 32'h0);

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
